// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences each instruction over
// several cycles, drives datapath strobes/selects, stalls on mem_ready, traps faults.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       jr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state
);
    localparam logic [3:0] IDLE     = 4'd0,  FETCH    = 4'd1,  DECODE   = 4'd2,
                           EXEC_R   = 4'd3,  RWB      = 4'd4,  JR       = 4'd5,
                           MEMADDR  = 4'd6,  MEMREAD  = 4'd7,  MEMWB    = 4'd8,
                           MEMWRITE = 4'd9,  BRANCH   = 4'd10, JUMP     = 4'd11,
                           IMM_EXEC = 4'd12, IMM_WB   = 4'd13, FAULT    = 4'd14;

    localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_ADDI = 6'd8,
                           OP_ANDI = 6'd12, OP_LW = 6'd35, OP_SW = 6'd43;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    typedef struct packed {
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } sel_t;

    sel_t       sel, sel_q;
    logic [3:0] nxt;
    logic [7:0] wait_cnt;
    logic       mem_wait, timeout, set_ill;

    assign mem_wait = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign timeout  = mem_wait && !mem_ready && (wait_cnt == TMO);

    always_comb begin
        nxt     = state;
        set_ill = 1'b0;
        case (state)
            IDLE:     nxt = FETCH;
            FETCH:    if (mem_ready) nxt = DECODE; else if (timeout) nxt = FAULT;
            DECODE: begin
                case (opcode)
                    OP_R:           nxt = jr ? JR : EXEC_R;
                    OP_LW, OP_SW:   nxt = MEMADDR;
                    OP_BEQ:         nxt = BRANCH;
                    OP_J:           nxt = JUMP;
                    OP_ADDI, OP_ANDI: nxt = IMM_EXEC;
                    default: begin
                        nxt     = FAULT;
                        set_ill = 1'b1;
                    end
                endcase
            end
            EXEC_R:   nxt = RWB;
            MEMADDR:  nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) nxt = MEMWB; else if (timeout) nxt = FAULT;
            MEMWRITE: if (mem_ready) nxt = FETCH; else if (timeout) nxt = FAULT;
            IMM_EXEC: nxt = IMM_WB;
            RWB, JR, MEMWB, BRANCH, JUMP, IMM_WB: nxt = FETCH;
            FAULT:    nxt = FAULT;
            default:  nxt = FAULT;
        endcase
    end

    // Mux selects a state does not drive keep their last value via sel_q.
    always_comb begin
        sel           = sel_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        case (state)
            FETCH: begin
                mem_read       = 1'b1;
                ir_write       = mem_ready;
                pc_write       = mem_ready;
                sel.iord       = 1'b0;
                sel.alu_src_a  = 1'b0;
                sel.alu_src_b  = 2'b01;
                sel.alu_op     = 2'b00;
                sel.pc_source  = 2'b00;
            end
            DECODE: begin
                sel.alu_src_a = 1'b0;
                sel.alu_src_b = 2'b11;
                sel.alu_op    = 2'b00;
            end
            EXEC_R: begin
                sel.alu_src_a = 1'b1;
                sel.alu_src_b = 2'b00;
                sel.alu_op    = 2'b10;
            end
            RWB: begin
                sel.reg_dst    = 1'b1;
                sel.mem_to_reg = 1'b0;
                reg_write      = 1'b1;
                instr_done     = 1'b1;
            end
            JR: begin
                sel.pc_source = 2'b11;
                pc_write      = 1'b1;
                instr_done    = 1'b1;
            end
            MEMADDR: begin
                sel.alu_src_a = 1'b1;
                sel.alu_src_b = 2'b10;
                sel.alu_op    = 2'b00;
            end
            MEMREAD: begin
                sel.iord = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                sel.reg_dst    = 1'b0;
                sel.mem_to_reg = 1'b1;
                reg_write      = 1'b1;
                instr_done     = 1'b1;
            end
            MEMWRITE: begin
                sel.iord   = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            BRANCH: begin
                sel.alu_src_a = 1'b1;
                sel.alu_src_b = 2'b00;
                sel.alu_op    = 2'b01;
                sel.pc_source = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            JUMP: begin
                sel.pc_source = 2'b10;
                pc_write      = 1'b1;
                instr_done    = 1'b1;
            end
            IMM_EXEC: begin
                sel.alu_src_a = 1'b1;
                sel.alu_src_b = 2'b10;
                sel.alu_op    = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
            end
            IMM_WB: begin
                sel.reg_dst    = 1'b0;
                sel.mem_to_reg = 1'b0;
                reg_write      = 1'b1;
                instr_done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign iord       = sel.iord;
    assign reg_dst    = sel.reg_dst;
    assign mem_to_reg = sel.mem_to_reg;
    assign alu_src_a  = sel.alu_src_a;
    assign alu_src_b  = sel.alu_src_b;
    assign alu_op     = sel.alu_op;
    assign pc_source  = sel.pc_source;

    // Any state change clears the wait counter, which covers every entry into a wait state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel_q     <= '0;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state <= nxt;
            sel_q <= sel;
            if (nxt != state)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (set_ill) illegal <= 1'b1;
            if (timeout) bus_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations are queued as
// stimulus is driven and checked by a monitor just after each falling edge.
module tb_multicycle_control;
    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
                           RWB = 4'd4, JR = 4'd5, MEMADDR = 4'd6, MEMREAD = 4'd7,
                           MEMWB = 4'd8, MEMWRITE = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                           IMM_EXEC = 4'd12, IMM_WB = 4'd13, FAULT = 4'd14;

    logic       clk, reset_n, jr, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal, bus_error;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .jr(jr), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
        .bus_error(bus_error), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [6:0] strb;
        logic [9:0] sel;
        logic [9:0] msk;
        logic       ill;
        logic       berr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // strb = {pc_write,pc_write_cond,mem_read,mem_write,ir_write,reg_write,instr_done}
    // sel  = {iord,reg_dst,mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_source}
    function automatic void exp_outs(input logic [3:0] st, input logic mr, input logic [5:0] opc,
                                     output logic [6:0] strb, output logic [9:0] sel,
                                     output logic [9:0] msk);
        strb = '0; sel = '0; msk = '0;
        case (st)
            IDLE:     msk = 10'b1_1_1_1_11_11_11;
            FETCH:    begin strb = {mr, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0};
                            sel = 10'b0_0_0_0_01_00_00; msk = 10'b1_0_0_1_11_11_11; end
            DECODE:   begin sel = 10'b0_0_0_0_11_00_00; msk = 10'b0_0_0_1_11_11_00; end
            EXEC_R:   begin sel = 10'b0_0_0_1_00_10_00; msk = 10'b0_0_0_1_11_11_00; end
            RWB:      begin strb = 7'b0000011; sel = 10'b0_1_0_0_00_00_00; msk = 10'b0_1_1_0_00_00_00; end
            JR:       begin strb = 7'b1000001; sel = 10'b0_0_0_0_00_00_11; msk = 10'b0_0_0_0_00_00_11; end
            MEMADDR:  begin sel = 10'b0_0_0_1_10_00_00; msk = 10'b0_0_0_1_11_11_00; end
            MEMREAD:  begin strb = 7'b0010000; sel = 10'b1_0_0_0_00_00_00; msk = 10'b1_0_0_0_00_00_00; end
            MEMWB:    begin strb = 7'b0000011; sel = 10'b0_0_1_0_00_00_00; msk = 10'b0_1_1_0_00_00_00; end
            MEMWRITE: begin strb = {6'b000100, mr}; sel = 10'b1_0_0_0_00_00_00; msk = 10'b1_0_0_0_00_00_00; end
            BRANCH:   begin strb = 7'b0100001; sel = 10'b0_0_0_1_00_01_01; msk = 10'b0_0_0_1_11_11_11; end
            JUMP:     begin strb = 7'b1000001; sel = 10'b0_0_0_0_00_00_10; msk = 10'b0_0_0_0_00_00_11; end
            IMM_EXEC: begin sel = (opc == 6'd12) ? 10'b0_0_0_1_10_11_00 : 10'b0_0_0_1_10_00_00;
                            msk = 10'b0_0_0_1_11_11_00; end
            IMM_WB:   begin strb = 7'b0000011; sel = 10'b0_0_0_0_00_00_00; msk = 10'b0_1_1_0_00_00_00; end
            default:  ;
        endcase
    endfunction

    // Drive one cycle's inputs, queue what the DUT must show during it, then advance.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [5:0] opc,
                       input logic j, input logic mr, input logic ill, input logic berr);
        exp_t e;
        opcode = opc; jr = j; mem_ready = mr;
        e.tag = tag; e.st = st; e.ill = ill; e.berr = berr;
        exp_outs(st, mr, opc, e.strb, e.sel, e.msk);
        q.push_back(e);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.tag, ".state"}, 32'(state), 32'(e.st));
            chk({e.tag, ".strb"}, 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write,
                                       reg_write, instr_done}), 32'(e.strb));
            chk({e.tag, ".sel"}, 32'({iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                                      pc_source} & e.msk), 32'(e.sel & e.msk));
            chk({e.tag, ".illegal"}, 32'(illegal), 32'(e.ill));
            chk({e.tag, ".bus_error"}, 32'(bus_error), 32'(e.berr));
        end
    end

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, ".rst_state"}, 32'(state), 32'(IDLE));
        chk({tag, ".rst_flags"}, 32'({illegal, bus_error}), 0);
        chk({tag, ".rst_strb"}, 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write,
                                     reg_write, instr_done}), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; opcode = '0; jr = 1'b0; mem_ready = 1'b0;
        #2;
        chk("reset.state", 32'(state), 32'(IDLE));
        chk("reset.outs", 32'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                               pc_source, instr_done, illegal, bus_error}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1: R-format
        cyc("r.idle",   IDLE,   6'd0, 0, 1, 0, 0);
        cyc("r.fetch",  FETCH,  6'd0, 0, 1, 0, 0);
        cyc("r.decode", DECODE, 6'd0, 0, 1, 0, 0);
        cyc("r.exec",   EXEC_R, 6'd0, 0, 1, 0, 0);
        cyc("r.wb",     RWB,    6'd0, 0, 1, 0, 0);
        // 2: lw with three wait states in MEMREAD
        cyc("lw.fetch", FETCH,   6'd35, 0, 1, 0, 0);
        cyc("lw.dec",   DECODE,  6'd35, 0, 1, 0, 0);
        cyc("lw.addr",  MEMADDR, 6'd35, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("lw.wait", MEMREAD, 6'd35, 0, 0, 0, 0);
        cyc("lw.rd",    MEMREAD, 6'd35, 0, 1, 0, 0);
        cyc("lw.wb",    MEMWB,   6'd35, 0, 1, 0, 0);
        // 3: beq, j, andi, addi, sw with one wait, jr
        cyc("beq.fetch", FETCH,  6'd4, 0, 1, 0, 0);
        cyc("beq.dec",   DECODE, 6'd4, 0, 1, 0, 0);
        cyc("beq.br",    BRANCH, 6'd4, 0, 1, 0, 0);
        cyc("j.fetch",   FETCH,  6'd2, 0, 1, 0, 0);
        cyc("j.dec",     DECODE, 6'd2, 0, 1, 0, 0);
        cyc("j.jump",    JUMP,   6'd2, 0, 1, 0, 0);
        cyc("andi.fetch", FETCH,    6'd12, 0, 1, 0, 0);
        cyc("andi.dec",   DECODE,   6'd12, 0, 1, 0, 0);
        cyc("andi.exec",  IMM_EXEC, 6'd12, 0, 1, 0, 0);
        cyc("andi.wb",    IMM_WB,   6'd12, 0, 1, 0, 0);
        cyc("addi.fetch", FETCH,    6'd8, 0, 1, 0, 0);
        cyc("addi.dec",   DECODE,   6'd8, 0, 1, 0, 0);
        cyc("addi.exec",  IMM_EXEC, 6'd8, 0, 1, 0, 0);
        cyc("addi.wb",    IMM_WB,   6'd8, 0, 1, 0, 0);
        cyc("sw.fetch",  FETCH,    6'd43, 0, 1, 0, 0);
        cyc("sw.dec",    DECODE,   6'd43, 0, 1, 0, 0);
        cyc("sw.addr",   MEMADDR,  6'd43, 0, 1, 0, 0);
        cyc("sw.wait",   MEMWRITE, 6'd43, 0, 0, 0, 0);
        cyc("sw.wr",     MEMWRITE, 6'd43, 0, 1, 0, 0);
        cyc("jr.fetch",  FETCH,  6'd0, 1, 1, 0, 0);
        cyc("jr.dec",    DECODE, 6'd0, 1, 1, 0, 0);
        cyc("jr.jr",     JR,     6'd0, 1, 1, 0, 0);
        // 4: illegal opcode traps and sticks until reset
        cyc("ill.fetch", FETCH,  6'd63, 0, 1, 0, 0);
        cyc("ill.dec",   DECODE, 6'd63, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("ill.fault", FAULT, 6'd0, 0, 1, 1, 0);
        do_reset("ill");
        // 5: timeout after MEM_TIMEOUT+1 not-ready FETCH cycles
        cyc("to.idle", IDLE, 6'd0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("to.wait", FETCH, 6'd0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc("to.fault", FAULT, 6'd0, 0, 0, 0, 1);
        do_reset("to");
        // 5b: ready on the last allowed cycle wins over the timeout
        cyc("edge.idle", IDLE, 6'd0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("edge.wait", FETCH, 6'd0, 0, 0, 0, 0);
        cyc("edge.rdy",  FETCH,  6'd0, 0, 1, 0, 0);
        cyc("edge.dec",  DECODE, 6'd0, 0, 1, 0, 0);
        cyc("edge.exec", EXEC_R, 6'd0, 0, 1, 0, 0);
        cyc("edge.wb",   RWB,    6'd0, 0, 1, 0, 0);
        // 6: asynchronous reset in the middle of a store
        cyc("ar.fetch", FETCH,    6'd43, 0, 1, 0, 0);
        cyc("ar.dec",   DECODE,   6'd43, 0, 1, 0, 0);
        cyc("ar.addr",  MEMADDR,  6'd43, 0, 1, 0, 0);
        cyc("ar.wait",  MEMWRITE, 6'd43, 0, 0, 0, 0);
        #2;
        chk("ar.pre_mem_write", 32'(mem_write), 1);
        reset_n = 1'b0;
        #1;
        chk("ar.mem_write", 32'(mem_write), 0);
        chk("ar.state", 32'(state), 32'(IDLE));
        chk("ar.iord", 32'(iord), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc("ar.idle",  IDLE,  6'd0, 0, 1, 0, 0);
        cyc("ar.fetch2", FETCH, 6'd0, 0, 1, 0, 0);
        #3;
        chk("sb.drain", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
